// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes and an accumulator.
//
// Stage 1 captures accepted operands and opcode. Stage 2 holds the registered result and flags.
// Operand A can be replaced by the internal accumulator (acc_sel). The accumulator loads the
// result of an acc_sel operation when that result leaves the block.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        input handshake; A, B, Op_code, acc_sel sampled on transfer
//   A, B [WIDTH]               unsigned operands
//   Op_code [3]                operation select
//   acc_sel                    use accumulator in place of A
//   acc_clr                    synchronous accumulator clear (beats a coincident load)
//   out_valid / out_ready      output handshake
//   ALU_Out [WIDTH]            result
//   flag_zero/neg/ovf          status of ALU_Out
module alu_pipe #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op_code,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_ovf
);

    // Extended width holds the full-precision sums (at most 4*(2^W-1) + 2^W).
    localparam int unsigned ExtW = WIDTH + 3;

    // Stage 1
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;
    logic             r_s1_acc_sel;

    // Stage 2
    logic             r_s2_valid;
    logic             r_s2_acc_sel;
    logic [WIDTH-1:0] r_alu_out;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;

    logic [WIDTH-1:0] r_acc;
    // Set while an acc_sel operation is in flight; blocks new input until its result leaves.
    logic             r_lock;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_s1_adv;
    logic [ExtW-1:0]  w_a_ext;
    logic [ExtW-1:0]  w_b_ext;
    logic [ExtW-1:0]  w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    assign w_out_fire = r_s2_valid && out_ready;
    assign w_s1_adv   = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready   = (!r_s1_valid || w_s1_adv) && !r_lock;
    assign w_in_fire  = in_valid && in_ready;

    assign out_valid  = r_s2_valid;
    assign ALU_Out    = r_alu_out;
    assign flag_zero  = r_zero;
    assign flag_neg   = r_neg;
    assign flag_ovf   = r_ovf;

    assign w_a_ext    = {3'b000, r_s1_a};
    assign w_b_ext    = {3'b000, r_s1_b};
    // 2*A - B truncated to WIDTH bits, for the absolute-value op.
    assign w_diff     = {r_s1_a[WIDTH-2:0], 1'b0} - r_s1_b;

    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_ovf = 1'b0;
        case (r_s1_op)
            3'b000: begin
                w_sum = (w_a_ext << 2) + (w_b_ext >> 1);
                w_res = w_sum[WIDTH-1:0];
                w_ovf = |w_sum[ExtW-1:WIDTH];
            end
            3'b001: begin
                w_sum = w_a_ext + w_b_ext + (w_b_ext << 1);
                w_res = w_sum[WIDTH-1:0];
                w_ovf = |w_sum[ExtW-1:WIDTH];
            end
            3'b010: w_res = {WIDTH{1'b0}} - r_s1_b;
            3'b011: w_res = w_diff[WIDTH-1] ? ({WIDTH{1'b0}} - w_diff) : w_diff;
            3'b100: begin
                w_sum = w_a_ext + w_b_ext;
                w_res = w_sum[WIDTH-1:0];
                w_ovf = |w_sum[ExtW-1:WIDTH];
            end
            3'b101: begin
                w_res = r_s1_a - r_s1_b;
                w_ovf = r_s1_a < r_s1_b;
            end
            3'b110: w_res = r_s1_a & r_s1_b;
            default: w_res = r_s1_a ^ r_s1_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_op      <= 3'b000;
            r_s1_acc_sel <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s2_acc_sel <= 1'b0;
            r_alu_out    <= '0;
            r_zero       <= 1'b0;
            r_neg        <= 1'b0;
            r_ovf        <= 1'b0;
            r_acc        <= '0;
            r_lock       <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid   <= 1'b1;
                r_s1_a       <= acc_sel ? r_acc : A;
                r_s1_b       <= B;
                r_s1_op      <= Op_code;
                r_s1_acc_sel <= acc_sel;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_s2_valid   <= 1'b1;
                r_s2_acc_sel <= r_s1_acc_sel;
                r_alu_out    <= w_res;
                r_zero       <= (w_res == '0);
                r_neg        <= w_res[WIDTH-1];
                r_ovf        <= w_ovf;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end

            if (acc_clr) begin
                r_acc <= '0;
            end else if (w_out_fire && r_s2_acc_sel) begin
                r_acc <= r_alu_out;
            end

            // Set and clear cannot coincide: acceptance needs r_lock low, release needs it high.
            if (w_in_fire && acc_sel) begin
                r_lock <= 1'b1;
            end else if (w_out_fire && r_s2_acc_sel) begin
                r_lock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   Op_code;
    logic         acc_sel;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_Out;
    logic         flag_zero;
    logic         flag_neg;
    logic         flag_ovf;

    int n_pass  = 0;
    int n_total = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Op_code   (Op_code),
        .acc_sel   (acc_sel),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_Out   (ALU_Out),
        .flag_zero (flag_zero),
        .flag_neg  (flag_neg),
        .flag_ovf  (flag_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {flag_zero, flag_neg, flag_ovf};
    endfunction

    // Reference: returns {zero, neg, ovf, result[5:0]}.
    function automatic logic [8:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        int ia;
        int ib;
        int s;
        int r;
        logic o;
        ia = int'(a);
        ib = int'(b);
        s  = 0;
        r  = 0;
        o  = 1'b0;
        case (op)
            3'd0: begin s = ia * 4 + ib / 2; r = s % 64; o = (s >= 64); end
            3'd1: begin s = ia + 3 * ib;     r = s % 64; o = (s >= 64); end
            3'd2: r = (64 - ib) % 64;
            3'd3: begin s = (2 * ia - ib + 128) % 64; r = (s >= 32) ? 64 - s : s; end
            3'd4: begin s = ia + ib;         r = s % 64; o = (s >= 64); end
            3'd5: begin r = (ia - ib + 64) % 64; o = (ia < ib); end
            3'd6: r = ia & ib;
            default: r = ia ^ ib;
        endcase
        return {(r == 0), (r >= 32), o, 6'(r)};
    endfunction

    // One operation through an empty pipe with out_ready held high.
    task automatic send_one(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic sel, input logic [W-1:0] exp,
                            input logic [2:0] expf);
        Op_code   = op;
        A         = a;
        B         = b;
        acc_sel   = sel;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "/in_ready"}, 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        A        = 6'h2a;
        B        = 6'h15;
        acc_sel  = 1'b0;
        chk({tag, "/lat1_valid"}, 32'(out_valid), 0);
        chk({tag, "/lock1"}, 32'(in_ready), 32'(!sel));
        tick();
        chk({tag, "/valid"}, 32'(out_valid), 1);
        chk({tag, "/result"}, 32'(ALU_Out), 32'(exp));
        chk({tag, "/flags"}, 32'(flags()), 32'(expf));
        chk({tag, "/lock2"}, 32'(in_ready), 32'(!sel));
        tick();
        chk({tag, "/drained"}, 32'(out_valid), 0);
        chk({tag, "/ready_after"}, 32'(in_ready), 1);
    endtask

    initial begin
        logic [8:0] q[$];
        logic [8:0] e;
        int accepted;
        int cyc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Op_code   = 3'd0;
        acc_sel   = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst/out_valid", 32'(out_valid), 0);
        chk("rst/in_ready", 32'(in_ready), 1);
        chk("rst/alu_out", 32'(ALU_Out), 0);
        chk("rst/flags", 32'(flags()), 0);

        // Directed op coverage: results and flags {z,n,o}
        send_one("op0_5_9",   3'd0, 6'd5,  6'd9,  1'b0, 6'd24, 3'b000);
        send_one("op3_3_10",  3'd3, 6'd3,  6'd10, 1'b0, 6'd4,  3'b000);
        send_one("op1_40_10", 3'd1, 6'd40, 6'd10, 1'b0, 6'd6,  3'b001);
        send_one("op2_b1",    3'd2, 6'd0,  6'd1,  1'b0, 6'd63, 3'b010);
        send_one("op0_carry", 3'd0, 6'd15, 6'd10, 1'b0, 6'd1,  3'b001);
        send_one("op4_wrap",  3'd4, 6'd63, 6'd1,  1'b0, 6'd0,  3'b101);
        send_one("op5_borrow",3'd5, 6'd2,  6'd5,  1'b0, 6'd61, 3'b011);
        send_one("op5_equal", 3'd5, 6'd5,  6'd5,  1'b0, 6'd0,  3'b100);
        send_one("op6_and",   3'd6, 6'd42, 6'd15, 1'b0, 6'd10, 3'b000);
        send_one("op7_xor",   3'd7, 6'd42, 6'd63, 1'b0, 6'd21, 3'b000);
        send_one("op3_pos",   3'd3, 6'd40, 6'd10, 1'b0, 6'd6,  3'b000);
        send_one("op3_min",   3'd3, 6'd16, 6'd0,  1'b0, 6'd32, 3'b010);

        // Backpressure: two accepted, third blocked, ordered release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        Op_code   = 3'd4;
        acc_sel   = 1'b0;
        A = 6'd1; B = 6'd1;
        #1;
        chk("bp/rdy0", 32'(in_ready), 1);
        tick();
        A = 6'd2; B = 6'd2;
        chk("bp/rdy1", 32'(in_ready), 1);
        tick();
        A = 6'd3; B = 6'd3;
        chk("bp/full_rdy", 32'(in_ready), 0);
        chk("bp/v2", 32'(out_valid), 1);
        chk("bp/r2", 32'(ALU_Out), 2);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp/hold_r2", 32'(ALU_Out), 2);
            chk("bp/hold_v2", 32'(out_valid), 1);
            chk("bp/hold_rdy", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp/release_rdy", 32'(in_ready), 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp/r4", 32'(ALU_Out), 4);
        tick();
        chk("bp/hold_r4", 32'(ALU_Out), 4);
        chk("bp/hold_v4", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        chk("bp/r6", 32'(ALU_Out), 6);
        chk("bp/v6", 32'(out_valid), 1);
        tick();
        chk("bp/empty", 32'(out_valid), 0);

        // Clear wins over a coincident accumulator load
        Op_code  = 3'd4; acc_sel = 1'b1; A = 6'd63; B = 6'd22;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        acc_sel  = 1'b0;
        tick();
        chk("clr/result", 32'(ALU_Out), 22);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        send_one("clr/acc_zero", 3'd4, 6'd63, 6'd0, 1'b1, 6'd0, 3'b100);

        // Accumulate 7 three times from a cleared accumulator
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        send_one("acc/7",  3'd4, 6'd63, 6'd7, 1'b1, 6'd7,  3'b000);
        send_one("acc/14", 3'd4, 6'd63, 6'd7, 1'b1, 6'd14, 3'b000);
        send_one("acc/21", 3'd4, 6'd63, 6'd7, 1'b1, 6'd21, 3'b000);
        send_one("acc/plain", 3'd4, 6'd1, 6'd1, 1'b0, 6'd2, 3'b000);
        send_one("acc/read21", 3'd6, 6'd0, 6'd63, 1'b1, 6'd21, 3'b000);

        // Reset with both stages full and output stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        Op_code   = 3'd4; acc_sel = 1'b0;
        A = 6'd1; B = 6'd1;
        tick();
        A = 6'd2; B = 6'd2;
        tick();
        in_valid = 1'b0;
        chk("rst2/pre_full", 32'(in_ready), 0);
        reset   = 1'b1;
        acc_clr = 1'b1;
        tick();
        reset   = 1'b0;
        acc_clr = 1'b0;
        chk("rst2/out_valid", 32'(out_valid), 0);
        chk("rst2/in_ready", 32'(in_ready), 1);
        chk("rst2/alu_out", 32'(ALU_Out), 0);
        chk("rst2/flags", 32'(flags()), 0);
        out_ready = 1'b1;
        tick();
        chk("rst2/no_ghost1", 32'(out_valid), 0);
        tick();
        chk("rst2/no_ghost2", 32'(out_valid), 0);
        send_one("rst2/acc5", 3'd4, 6'd63, 6'd5, 1'b1, 6'd5, 3'b000);

        // Back-to-back random traffic against the reference model
        accepted = 0;
        cyc      = 0;
        while ((accepted < 40 || q.size() != 0) && cyc < 2000) begin
            in_valid  = (accepted < 40) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            Op_code   = 3'($urandom_range(0, 7));
            A         = 6'($urandom_range(0, 63));
            B         = 6'($urandom_range(0, 63));
            acc_sel   = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd/unexpected_output", 32'(q.size()), 1);
                end else begin
                    e = q.pop_front();
                    chk("rnd/result", 32'(ALU_Out), 32'(e[5:0]));
                    chk("rnd/flags", 32'(flags()), 32'(e[8:6]));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(Op_code, A, B));
                accepted++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("rnd/outstanding", 32'(q.size()) + 32'(40 - accepted), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 6: operand, result and accumulator width in bits; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand/opcode presented this cycle.
REQ-005 in_ready  output  1  block accepts operands this cycle; transfer when in_valid && in_ready.
REQ-006 A  input  WIDTH  operand A, unsigned.
REQ-007 B  input  WIDTH  operand B, unsigned.
REQ-008 Op_code  input  3  operation select (REQ-014).
REQ-009 acc_sel  input  1  use internal accumulator in place of A.
REQ-010 acc_clr  input  1  synchronous clear of accumulator.
REQ-011 out_valid  output  1  result presented; transfer when out_valid && out_ready.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 ALU_Out  output  WIDTH  result; flag_zero, flag_neg, flag_ovf  output  1 each  status of ALU_Out.

Function
REQ-014 Op_code map, all arithmetic modulo 2^WIDTH: 000 (A<<2)+(B>>1) logical shifts; 001 A+3*B; 010 -B; 011 |2*A-B| (compute 2*A-B in WIDTH bits, negate if MSB=1); 100 A+B; 101 A-B; 110 A&B; 111 A^B.
REQ-015 Operand A used by REQ-014 is the accumulator value when acc_sel=1 at acceptance, otherwise port A.
REQ-016 Two register stages: stage 1 captures accepted operands/opcode; stage 2 holds result and flags; ALU_Out and flags driven only from stage 2 registers.
REQ-017 Latency: operands accepted at edge N appear with out_valid=1 after edge N+2 when unstalled; throughput one operation per cycle.
REQ-018 Stage 1 advances to stage 2 when stage 2 empty or its result transfers that cycle; in_ready = (stage 1 empty or stage 1 advancing) and no accumulator interlock (REQ-022).
REQ-019 While out_valid=1 and out_ready=0, ALU_Out, flags and out_valid hold stable; no result lost, duplicated or reordered.
REQ-020 flag_zero = (ALU_Out==0); flag_neg = ALU_Out[WIDTH-1]; flag_ovf = carry out of bit WIDTH-1 for ops 000, 001, 100 (full-precision sum >= 2^WIDTH), borrow (A<B) for 101, 0 for 010, 011, 110, 111.
REQ-021 Accumulator (WIDTH bits) loads ALU_Out at the edge where an acc_sel=1 result transfers at the output; results of acc_sel=0 operations never update it.
REQ-022 Interlock: from acceptance of an acc_sel=1 operation until its output transfer, in_ready=0.
REQ-023 acc_clr=1 sets accumulator to 0 at next edge; if coincident with a REQ-021 load, clear wins.
REQ-024 in_valid with in_ready=0 is ignored; A, B, Op_code, acc_sel sampled only on transfer.

Reset
REQ-025 reset=1 at an edge: both stages emptied, out_valid=0, in_ready=1 next cycle, ALU_Out=0, all flags=0, accumulator=0, interlock cleared.
REQ-026 Reset mid-operation discards all in-flight operations; no output transfer for them after reset.
REQ-027 reset has priority over every other input including acc_clr and handshakes.

Verification
REQ-028 WIDTH=6, Op_code=000, A=5, B=9, out_ready=1 -> ALU_Out=24 two cycles after acceptance, flags z=0 n=0 o=0.
REQ-029 Op_code=011, A=3, B=10 -> ALU_Out=4; Op_code=001, A=40, B=10 -> ALU_Out=6, flag_ovf=1; Op_code=010, B=1 -> ALU_Out=63, flag_neg=1.
REQ-030 out_ready=0, in_valid=1 with three ops (100: 1+1, 2+2, 3+3) -> exactly two accepted then in_ready=0; release out_ready -> outputs 2, 4, 6 in order, each held stable while stalled.
REQ-031 acc_clr pulse, then three ops Op_code=100, acc_sel=1, B=7 -> outputs 7, 14, 21; in_ready=0 between acceptance and each output transfer; accumulator=21 at end.
REQ-032 reset asserted with both stages full and out_ready=0 -> next cycle out_valid=0, in_ready=1, ALU_Out=0, flags 0; subsequent acc_sel=1 op 100 with B=5 -> ALU_Out=5.
REQ-033 Random back-to-back ops with random out_ready vs. a reference model per REQ-014/020 -> all results match, in order, none dropped.
